// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Colour codes and button-capture FSM states shared across the game.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam logic [1:0] COL_0 = 2'd0;
    localparam logic [1:0] COL_1 = 2'd1;
    localparam logic [1:0] COL_2 = 2'd2;
    localparam logic [1:0] COL_3 = 2'd3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        PRESSED    = 3'd2,
        LOCKOUT    = 3'd3,
        DB_RELEASE = 3'd4
    } btn_state_t;

    // Only ever called on a confirmed single-button pattern.
    function automatic logic [1:0] onehot_to_colour(input logic [3:0] v);
        case (v)
            4'b0010: return COL_1;
            4'b0100: return COL_2;
            4'b1000: return COL_3;
            default: return COL_0;
        endcase
    endfunction

    function automatic logic is_multi(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : button_capture_if
// Purpose  : Valid/ready press-event channel from button capture to wait state.
// Revision : 1.0 - initial release
// ============================================================================
interface button_capture_if;
    logic       press_valid;
    logic [1:0] press_colour;
    logic       press_ready;

    modport master (output press_valid, output press_colour, input press_ready);
    modport slave  (input press_valid, input press_colour, output press_ready);
endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for asynchronous inputs, parameterizable width.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;
endmodule
`default_nettype wire

// File: rtl/button_capture.sv
`default_nettype none
// ============================================================================
// Module   : button_capture
// Purpose  : Debounces four button pins into single colour press events with
//            multi-press and overrun detection.
// Revision : 1.0 - initial release
// ============================================================================
module button_capture
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [3:0]  buttons_raw,
    button_capture_if.master press_if,
    output logic             multi_press_err,
    output logic             overrun,
    output logic             any_held
);
    localparam logic [CNT_W-1:0] C_DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [3:0]       w_sync;
    logic [3:0]       r_sync_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             w_changed;
    logic             w_confirmed;
    btn_state_t       r_state;
    btn_state_t       w_state_next;
    logic             w_enter_pressed;
    logic             w_multi_err;
    logic             r_valid;
    logic [1:0]       r_colour;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (buttons_raw),
        .q     (w_sync)
    );

    assign w_changed   = (w_sync != r_sync_prev);
    assign w_confirmed = !w_changed && (r_cnt == C_DB_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_prev <= '0;
            r_cnt       <= '0;
        end else begin
            r_sync_prev <= w_sync;
            if (w_changed)
                r_cnt <= '0;
            else if (r_cnt != C_DB_MAX)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next    = r_state;
        w_enter_pressed = 1'b0;
        w_multi_err     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_sync != 4'd0)
                    w_state_next = DB_PRESS;
            end
            DB_PRESS: begin
                if (w_sync == 4'd0) begin
                    w_state_next = IDLE;
                end else if (w_confirmed) begin
                    if (is_multi(w_sync)) begin
                        w_state_next = LOCKOUT;
                        w_multi_err  = 1'b1;
                    end else begin
                        w_state_next    = PRESSED;
                        w_enter_pressed = 1'b1;
                    end
                end
            end
            PRESSED: begin
                // Any deviation, including an added button, starts the release debounce.
                if (w_changed)
                    w_state_next = DB_RELEASE;
            end
            LOCKOUT: begin
                if (w_sync == 4'd0)
                    w_state_next = DB_RELEASE;
            end
            DB_RELEASE: begin
                if (w_confirmed && (w_sync == 4'd0))
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid         <= 1'b0;
            r_colour        <= COL_0;
            multi_press_err <= 1'b0;
            overrun         <= 1'b0;
            any_held        <= 1'b0;
        end else begin
            any_held        <= (w_state_next != IDLE);
            multi_press_err <= w_multi_err;
            overrun         <= w_enter_pressed && r_valid && !press_if.press_ready;
            // A transfer on the same edge frees the slot for the new event.
            if (w_enter_pressed && (!r_valid || press_if.press_ready)) begin
                r_valid  <= 1'b1;
                r_colour <= onehot_to_colour(w_sync);
            end else if (r_valid && press_if.press_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign press_if.press_valid  = r_valid;
    assign press_if.press_colour = r_colour;
endmodule
`default_nettype wire

// File: tb/tb_button_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_capture
// Purpose  : Scoreboard bench for button_capture with DEBOUNCE_CYCLES = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_capture;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] buttons_raw;
    logic       multi_press_err;
    logic       overrun;
    logic       any_held;

    button_capture_if bif ();

    button_capture #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .buttons_raw     (buttons_raw),
        .press_if        (bif.master),
        .multi_press_err (multi_press_err),
        .overrun         (overrun),
        .any_held        (any_held)
    );

    always #5 clk = ~clk;

    int         total   = 0;
    int         bad     = 0;
    int         err_cnt = 0;
    int         ovr_cnt = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares every presented event against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (multi_press_err) err_cnt++;
            if (overrun)         ovr_cnt++;
            if (bif.press_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: colour=%0d presented, none expected", bif.press_colour);
                end else begin
                    check("event_colour", int'(bif.press_colour), int'(exp_q[0]));
                    if (bif.press_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic hold(input logic [3:0] p, input int n);
        buttons_raw = p;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Edge index counted from the first sampling edge (index 1); valid rises DB+3 edges later.
    task automatic press_latency(input logic [3:0] p, input string name);
        int k;
        k = 0;
        buttons_raw = p;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bif.press_valid) begin
                k = i;
                break;
            end
        end
        check(name, k, DB + 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0;
        int o0;
        reset           = 1'b1;
        buttons_raw     = 4'd0;
        bif.press_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(bif.press_valid), 0);
        check("rst_err", int'(multi_press_err), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_any_held", int'(any_held), 0);
        reset = 1'b0;
        hold(4'd0, 3);

        // Clean press of colour 2
        exp_q.push_back(2'd2);
        press_latency(4'b0100, "clean_latency");
        check("clean_any_held", int'(any_held), 1);
        @(posedge clk); #1;
        check("clean_one_cycle", int'(bif.press_valid), 0);
        hold(4'b0100, 11);
        hold(4'd0, 10);
        check("clean_released", int'(any_held), 0);
        check("clean_q_empty", exp_q.size(), 0);

        // Bouncing bit1 then a stable press
        e0 = err_cnt;
        for (int i = 0; i < 3; i++) begin
            hold(4'b0010, 2);
            hold(4'b0000, 2);
        end
        exp_q.push_back(2'd1);
        hold(4'b0010, 10);
        hold(4'd0, 10);
        check("bounce_q_empty", exp_q.size(), 0);
        check("bounce_no_err", err_cnt - e0, 0);

        // Multi-button press is locked out, then a clean colour 0
        e0 = err_cnt;
        hold(4'b1001, 10);
        check("multi_no_valid", int'(bif.press_valid), 0);
        hold(4'd0, 10);
        check("multi_err_once", err_cnt - e0, 1);
        exp_q.push_back(2'd0);
        hold(4'b0001, 10);
        hold(4'd0, 10);
        check("multi_next_q_empty", exp_q.size(), 0);

        // Backpressure: second press dropped with overrun
        o0 = ovr_cnt;
        bif.press_ready = 1'b0;
        exp_q.push_back(2'd3);
        hold(4'b1000, 10);
        check("bp_valid", int'(bif.press_valid), 1);
        hold(4'd0, 10);
        hold(4'b0001, 10);
        check("bp_overrun_once", ovr_cnt - o0, 1);
        check("bp_colour_held", int'(bif.press_colour), 3);
        hold(4'd0, 10);
        bif.press_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_cleared", int'(bif.press_valid), 0);
        check("bp_q_empty", exp_q.size(), 0);

        // Reset two cycles into the press debounce
        buttons_raw = 4'b0010;
        repeat (5) @(posedge clk);
        #1;
        check("mid_any_held", int'(any_held), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", int'(bif.press_valid), 0);
        check("mid_rst_any_held", int'(any_held), 0);
        check("mid_rst_err", int'(multi_press_err), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        exp_q.push_back(2'd1);
        press_latency(4'b0010, "mid_rst_latency");
        hold(4'b0010, 5);
        hold(4'd0, 10);
        check("mid_q_empty", exp_q.size(), 0);

        // New press during release debounce is ignored until a clean release
        exp_q.push_back(2'd0);
        hold(4'b0001, 10);
        hold(4'd0, 2);
        hold(4'b0100, 10);
        check("rel_no_event", exp_q.size(), 0);
        check("rel_still_held", int'(any_held), 1);
        hold(4'd0, 10);
        exp_q.push_back(2'd2);
        hold(4'b0100, 10);
        hold(4'd0, 10);
        check("rel_fresh_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
